// File: rtl/multiple_sum_pkg.sv
// Shared definitions for the multiple-sum engine: state encoding and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package multiple_sum_pkg;

  localparam int DEF_NCH   = 2;
  localparam int DEF_N_W   = 16;
  localparam int DEF_DIV_W = 8;
  localparam int DEF_SUM_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/msum_min_sel.sv
// Minimum of up to four valid values, with any-valid flag and equal-to-min mask.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module msum_min_sel #(
  parameter int NCH = 2,
  parameter int W   = 17
) (
  input  logic [NCH*W-1:0] val,
  input  logic [NCH-1:0]   vld,
  output logic [W-1:0]     min_val,
  output logic             any_vld,
  output logic [NCH-1:0]   eq_mask
);

  // Pad to four slots so the tree shape stays balanced for any NCH in 1..4.
  logic [W-1:0] v [4];
  logic [3:0]   p;

  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < NCH) begin : g_real
      assign v[g] = val[g*W +: W];
      assign p[g] = vld[g];
    end else begin : g_fill
      assign v[g] = '0;
      assign p[g] = 1'b0;
    end
  end

  logic [W-1:0] m01, m23;
  logic         p01, p23;

  // Two-level compare tree; an invalid side always loses.
  always_comb begin
    m01 = (p[0] && (!p[1] || v[0] <= v[1])) ? v[0] : v[1];
    p01 = p[0] | p[1];
    m23 = (p[2] && (!p[3] || v[2] <= v[3])) ? v[2] : v[3];
    p23 = p[2] | p[3];
    min_val = (p01 && (!p23 || m01 <= m23)) ? m01 : m23;
    any_vld = p01 | p23;
  end

  // Every valid channel sitting on the minimum is flagged so ties advance together.
  for (genvar g = 0; g < NCH; g++) begin : g_eq
    assign eq_mask[g] = vld[g] && (val[g*W +: W] == min_val);
  end

endmodule

// File: rtl/multiple_sum_engine.sv
// Sums each natural number below limit that is a multiple of any enabled divisor, once.
// Latency: done pulses T+3 cycles after st is taken (T = terms found), one term per cycle.
// Backpressure: st is only honoured in IDLE; requests while busy or in DONE are dropped.
module multiple_sum_engine
  import multiple_sum_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int N_W   = DEF_N_W,
  parameter int DIV_W = DEF_DIV_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               st,
  input  logic [N_W-1:0]     limit,
  input  logic [NCH*DIV_W-1:0] div,
  input  logic [NCH-1:0]     ch_en,
  output logic               busy,
  output logic               done,
  output logic [SUM_W-1:0]   sum,
  output logic [N_W-1:0]     terms,
  output logic               ovf
);

  // Next-multiple registers carry one extra bit so nm + div can never wrap.
  localparam int NW1 = N_W + 1;
  localparam int AW  = ((SUM_W > N_W) ? SUM_W : N_W) + 1;

  state_t               state;
  logic [N_W-1:0]       lim;
  logic [NCH*NW1-1:0]   nm;
  logic [NCH*DIV_W-1:0] dv;
  logic [NCH-1:0]       active;
  logic [SUM_W-1:0]     acc;

  logic [NCH-1:0]       cand;
  logic [NCH-1:0]       eq_mask;
  logic [NW1-1:0]       m_val;
  logic                 any_cand;
  logic [AW-1:0]        acc_ext;

  // A channel competes while it is enabled and its next multiple is still below the limit.
  for (genvar g = 0; g < NCH; g++) begin : g_cand
    assign cand[g] = active[g] && (nm[g*NW1 +: NW1] < {1'b0, lim});
  end

  msum_min_sel #(
    .NCH (NCH),
    .W   (NW1)
  ) u_min (
    .val     (nm),
    .vld     (cand),
    .min_val (m_val),
    .any_vld (any_cand),
    .eq_mask (eq_mask)
  );

  // Widened add exposes the carry-out that feeds the sticky overflow flag.
  assign acc_ext = AW'(acc) + AW'(m_val);

  // Control FSM and datapath: load channels, emit the smallest pending multiple each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      terms  <= '0;
      ovf    <= 1'b0;
      lim    <= '0;
      nm     <= '0;
      dv     <= '0;
      active <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (st) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          lim <= limit;
          dv  <= div;
          for (int i = 0; i < NCH; i++) begin
            active[i]          <= ch_en[i] && (div[i*DIV_W +: DIV_W] != '0);
            nm[i*NW1 +: NW1]   <= NW1'(div[i*DIV_W +: DIV_W]);
          end
          acc   <= '0;
          terms <= '0;
          ovf   <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          if (!any_cand) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= acc;
          end else begin
            acc   <= acc_ext[SUM_W-1:0];
            terms <= terms + N_W'(1);
            if (|acc_ext[AW-1:SUM_W]) ovf <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
              if (eq_mask[i]) nm[i*NW1 +: NW1] <= nm[i*NW1 +: NW1] + NW1'(dv[i*DIV_W +: DIV_W]);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiple_sum_engine.sv
// Directed bench for multiple_sum_engine across three parameterisations.
// Latency: n/a.
// Backpressure: n/a.
module tb_multiple_sum_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] limit;
  logic [23:0] div3;
  logic [15:0] div2;
  logic [2:0]  en3;
  logic [1:0]  en2;
  logic st2, st3, st16;

  assign div2 = div3[15:0];
  assign en2  = en3[1:0];

  logic        busy2, done2, ovf2;
  logic [31:0] sum2;
  logic [15:0] terms2;
  logic        busy3, done3, ovf3;
  logic [31:0] sum3;
  logic [15:0] terms3;
  logic        busy16, done16, ovf16;
  logic [15:0] sum16;
  logic [15:0] terms16;

  multiple_sum_engine #(.NCH(2), .N_W(16), .DIV_W(8), .SUM_W(32)) u2 (
    .clk(clk), .rst_n(rst_n), .st(st2), .limit(limit), .div(div2), .ch_en(en2),
    .busy(busy2), .done(done2), .sum(sum2), .terms(terms2), .ovf(ovf2));

  multiple_sum_engine #(.NCH(3), .N_W(16), .DIV_W(8), .SUM_W(32)) u3 (
    .clk(clk), .rst_n(rst_n), .st(st3), .limit(limit), .div(div3), .ch_en(en3),
    .busy(busy3), .done(done3), .sum(sum3), .terms(terms3), .ovf(ovf3));

  multiple_sum_engine #(.NCH(2), .N_W(16), .DIV_W(8), .SUM_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .st(st16), .limit(limit), .div(div2), .ch_en(en2),
    .busy(busy16), .done(done16), .sum(sum16), .terms(terms16), .ovf(ovf16));

  int          sel;
  logic        m_busy, m_done, m_ovf;
  logic [31:0] m_sum;
  logic [15:0] m_terms;

  always_comb begin
    m_busy = busy2; m_done = done2; m_ovf = ovf2; m_sum = sum2; m_terms = terms2;
    case (sel)
      1: begin m_busy = busy3; m_done = done3; m_ovf = ovf3; m_sum = sum3; m_terms = terms3; end
      2: begin m_busy = busy16; m_done = done16; m_ovf = ovf16; m_sum = {16'h0, sum16}; m_terms = terms16; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [15:0] lim;
    logic [23:0] dv;
    logic [2:0]  en;
    logic [31:0] es;
    logic [15:0] et;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  task automatic set_st(input int id, input logic v);
    case (id)
      1: st3 = v;
      2: st16 = v;
      default: st2 = v;
    endcase
  endtask

  // Start one run on the selected instance and wait (bounded) for its done pulse.
  task automatic run(input int id, input logic [15:0] lim, input logic [23:0] dv,
                     input logic [2:0] en, output int lat, output logic seen);
    int cyc;
    repeat (2) @(negedge clk);
    sel = id; limit = lim; div3 = dv; en3 = en;
    set_st(id, 1'b1);
    @(posedge clk); #1;
    set_st(id, 1'b0);
    cyc = 1;
    while (!m_done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat  = cyc;
    seen = m_done;
  endtask

  initial begin
    int lat;
    int dcount;
    logic seen;
    logic [31:0] cap_sum;
    logic [15:0] cap_terms;

    rst_n = 1'b0; st2 = 0; st3 = 0; st16 = 0; sel = 0;
    limit = '0; div3 = '0; en3 = '0;

    //          id  lim    dv {c2,c1,c0}       en    sum     terms ovf
    vecs.push_back('{0, 16'd10,   {8'd0, 8'd5, 8'd3},  3'b011, 32'd23,     16'd4,   1'b0});
    vecs.push_back('{1, 16'd10,   {8'd5, 8'd3, 8'd2},  3'b111, 32'd37,     16'd7,   1'b0});
    vecs.push_back('{0, 16'd16,   {8'd0, 8'd0, 8'd3},  3'b011, 32'd45,     16'd5,   1'b0});
    vecs.push_back('{0, 16'd1,    {8'd0, 8'd5, 8'd3},  3'b011, 32'd0,      16'd0,   1'b0});
    vecs.push_back('{2, 16'd1000, {8'd0, 8'd5, 8'd3},  3'b011, 32'd36560,  16'd466, 1'b1});
    vecs.push_back('{2, 16'd10,   {8'd0, 8'd5, 8'd3},  3'b011, 32'd23,     16'd4,   1'b0});
    vecs.push_back('{0, 16'd5,    {8'd0, 8'd0, 8'd1},  3'b011, 32'd10,     16'd4,   1'b0});
    vecs.push_back('{0, 16'd10,   {8'd0, 8'd5, 8'd3},  3'b001, 32'd18,     16'd3,   1'b0});
    vecs.push_back('{0, 16'd10,   {8'd0, 8'd5, 8'd3},  3'b010, 32'd5,      16'd1,   1'b0});
    vecs.push_back('{0, 16'd13,   {8'd0, 8'd4, 8'd4},  3'b011, 32'd24,     16'd3,   1'b0});
    vecs.push_back('{0, 16'd10,   {8'd0, 8'd3, 8'd20}, 3'b011, 32'd18,     16'd3,   1'b0});
    vecs.push_back('{0, 16'd100,  {8'd0, 8'd5, 8'd3},  3'b000, 32'd0,      16'd0,   1'b0});
    vecs.push_back('{0, 16'd0,    {8'd0, 8'd5, 8'd3},  3'b011, 32'd0,      16'd0,   1'b0});
    vecs.push_back('{1, 16'd10,   {8'd2, 8'd2, 8'd2},  3'b111, 32'd20,     16'd4,   1'b0});
    vecs.push_back('{0, 16'd1000, {8'd0, 8'd5, 8'd3},  3'b011, 32'd233168, 16'd466, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  64'(busy2),  64'd0);
    chk("rst_done",  64'(done2),  64'd0);
    chk("rst_sum",   64'(sum2),   64'd0);
    chk("rst_terms", 64'(terms2), 64'd0);
    chk("rst_ovf",   64'(ovf2),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run(vecs[i].id, vecs[i].lim, vecs[i].dv, vecs[i].en, lat, seen);
      chk($sformatf("v%0d_done", i),  64'(seen),    64'd1);
      chk($sformatf("v%0d_sum", i),   64'(m_sum),   64'(vecs[i].es));
      chk($sformatf("v%0d_terms", i), 64'(m_terms), 64'(vecs[i].et));
      chk($sformatf("v%0d_ovf", i),   64'(m_ovf),   64'(vecs[i].eo));
      chk($sformatf("v%0d_lat", i),   64'(lat),     64'(3 + int'(vecs[i].et)));
    end

    // Mid-run reset: outputs clear at once and no done pulse follows.
    repeat (2) @(negedge clk);
    sel = 0; limit = 16'd1000; div3 = {8'd0, 8'd5, 8'd3}; en3 = 3'b011;
    st2 = 1'b1;
    @(posedge clk); #1;
    st2 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy2), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  64'(busy2),  64'd0);
    chk("arst_done",  64'(done2),  64'd0);
    chk("arst_sum",   64'(sum2),   64'd0);
    chk("arst_terms", 64'(terms2), 64'd0);
    chk("arst_ovf",   64'(ovf2),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done2) dcount++;
    end
    chk("arst_no_done", 64'(dcount), 64'd0);
    chk("arst_idle",    64'(busy2),  64'd0);

    // st held high while busy, inputs changed mid-run: single run on the loaded values.
    repeat (2) @(negedge clk);
    limit = 16'd10; div3 = {8'd0, 8'd5, 8'd3}; en3 = 3'b011;
    st2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    limit = 16'd1000; div3 = {8'd0, 8'd7, 8'd2}; en3 = 3'b000;
    dcount = 0; cap_sum = '0; cap_terms = '0;
    for (int c = 0; c < 40; c++) begin
      if (done2) begin
        dcount++;
        cap_sum = sum2;
        cap_terms = terms2;
        st2 = 1'b0;
      end
      @(posedge clk); #1;
    end
    st2 = 1'b0;
    chk("hold_done_cnt", 64'(dcount),    64'd1);
    chk("hold_sum",      64'(cap_sum),   64'd23);
    chk("hold_terms",    64'(cap_terms), 64'd4);
    chk("hold_no_busy",  64'(busy2),     64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
